// File: rtl/sll_shift.sv
// 32-bit logical left shifter: five cascaded barrel stages (16/8/4/2/1)
// feeding one output register, so each result appears one clock after its operands.
module sll_shift #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic [WIDTH-1:0]   Out
);

    // stage[SHAMT_W] is the raw operand; stage[0] is the fully shifted value
    logic [SHAMT_W:0][WIDTH-1:0] stage;

    assign stage[SHAMT_W] = A;

    for (genvar k = SHAMT_W - 1; k >= 0; k--) begin : g_stage
        localparam int SH = 1 << k;
        logic [WIDTH-1:0] shifted;

        assign shifted  = {stage[k+1][WIDTH-SH-1:0], {SH{1'b0}}};
        assign stage[k] = Shamt[k] ? shifted : stage[k+1];
    end

    // output register boundary
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Out <= '0;
        end else begin
            Out <= stage[0];
        end
    end

endmodule

// File: tb/tb_sll_shift.sv
// Self-checking bench for sll_shift: directed literal vectors plus a
// per-cycle comparison against an arithmetic (multiply-by-power-of-two) model.
module tb_sll_shift;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] A;
    logic [4:0]  Shamt;
    logic [31:0] Out;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_out = 32'h0;

    sll_shift #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .A       (A),
        .Shamt   (Shamt),
        .Out     (Out)
    );

    always #5 clock = ~clock;

    // Reference: a left shift by s is multiplication by 2**s, keeping the low 32 bits.
    function automatic logic [31:0] ref_sll(input logic [31:0] a, input logic [4:0] s);
        longint unsigned prod;
        prod = longint'(a) * (64'd1 << s);
        return prod[31:0];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_out <= 32'h0;
        else          model_out <= ref_sll(A, Shamt);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Per-cycle compare away from the active edge
    always @(negedge clock) begin
        if (reset_n !== 1'bx) check("model", Out, model_out);
    end

    task automatic apply(input string name, input logic [31:0] a, input logic [4:0] s,
                         input logic [31:0] req);
        @(negedge clock);
        A = a;
        Shamt = s;
        @(posedge clock);
        #1;
        check(name, Out, req);
    endtask

    logic [31:0] ra, rexp;
    logic [4:0]  rs;
    logic        eq;

    initial begin
        reset_n = 1'b0;
        A = 32'hFFFF_FFFF;
        Shamt = 5'd3;
        repeat (3) @(posedge clock);
        #1;
        check("reset_hold", Out, 32'h0);

        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("reset_release", Out, 32'hFFFF_FFF8);

        apply("identity",  32'h1234_5678, 5'd0,  32'h1234_5678);
        apply("max_shift", 32'h0000_0001, 5'd31, 32'h8000_0000);
        apply("discard",   32'h8000_0001, 5'd1,  32'h0000_0002);
        apply("zero_a",    32'h0000_0000, 5'd13, 32'h0000_0000);
        apply("s1",  32'hA5A5_A5A5, 5'd1,  32'h4B4B_4B4A);
        apply("s2",  32'hA5A5_A5A5, 5'd2,  32'h9696_9694);
        apply("s4",  32'hA5A5_A5A5, 5'd4,  32'h5A5A_5A50);
        apply("s8",  32'hA5A5_A5A5, 5'd8,  32'hA5A5_A500);
        apply("s16", 32'hA5A5_A5A5, 5'd16, 32'hA5A5_0000);
        apply("fill16", 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000);

        // Asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", Out, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rs = 5'($urandom_range(0, 31));
            rexp = ref_sll(ra, rs);
            apply("random", ra, rs, rexp);
            eq = (Out === rexp);
            $display("vec %0d A=%b Shamt=%b Out=%b exp=%b eq=%0d", i, ra, rs, Out, rexp, eq);
        end

        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
